// File: rtl/xfcp_arb_rr.sv
// Round-robin transaction arbiter: several upstream XFCP ports share one downstream port.
// Latency: one cycle to grant, then request and response beats pass through combinationally.
// Backpressure: only the granted port sees ready. An unsolicited or late response is sunk by DROP.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   up_xfcp_in_*             per-port request streams (tdata lane i at [8*i+7:8*i])
//   up_xfcp_out_*            per-port response streams (tdata shared across all lanes)
//   down_xfcp_out_*          request stream towards the switch
//   down_xfcp_in_*           response stream from the switch
//   busy                     high whenever the arbiter is not idle
//   timeout_pulse            one-cycle strobe when a grant is released by the response timeout
module xfcp_arb_rr #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*8-1:0] up_xfcp_in_tdata,
  input  logic [PORTS-1:0]   up_xfcp_in_tvalid,
  output logic [PORTS-1:0]   up_xfcp_in_tready,
  input  logic [PORTS-1:0]   up_xfcp_in_tlast,
  input  logic [PORTS-1:0]   up_xfcp_in_tuser,
  output logic [PORTS*8-1:0] up_xfcp_out_tdata,
  output logic [PORTS-1:0]   up_xfcp_out_tvalid,
  input  logic [PORTS-1:0]   up_xfcp_out_tready,
  output logic [PORTS-1:0]   up_xfcp_out_tlast,
  output logic [PORTS-1:0]   up_xfcp_out_tuser,
  output logic [7:0]         down_xfcp_out_tdata,
  output logic               down_xfcp_out_tvalid,
  input  logic               down_xfcp_out_tready,
  output logic               down_xfcp_out_tlast,
  output logic               down_xfcp_out_tuser,
  input  logic [7:0]         down_xfcp_in_tdata,
  input  logic               down_xfcp_in_tvalid,
  output logic               down_xfcp_in_tready,
  input  logic               down_xfcp_in_tlast,
  input  logic               down_xfcp_in_tuser,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  // Set once a non-final response beat has been delivered, so a timeout
  // must sink the remainder of that packet instead of going straight idle.
  logic             mid_resp_q, mid_resp_d;

  // Granted port's request lane and response ready
  logic [PORTS-1:0] gnt_oh;
  logic [7:0]       sel_tdata;
  logic             sel_tvalid, sel_tlast, sel_tuser, sel_out_tready;

  always_comb begin
    gnt_oh         = '0;
    sel_tdata      = '0;
    sel_tvalid     = 1'b0;
    sel_tlast      = 1'b0;
    sel_tuser      = 1'b0;
    sel_out_tready = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        gnt_oh[i]      = 1'b1;
        sel_tdata      = up_xfcp_in_tdata[8*i +: 8];
        sel_tvalid     = up_xfcp_in_tvalid[i];
        sel_tlast      = up_xfcp_in_tlast[i];
        sel_tuser      = up_xfcp_in_tuser[i];
        sel_out_tready = up_xfcp_out_tready[i];
      end
    end
  end

  // Round-robin pick: first valid port scanning rr_ptr, rr_ptr+1, ... mod PORTS.
  // Offsets are visited high to low so the smallest offset is written last and wins.
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W:0]   cand;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(PORTS)) begin
        cand = cand - (IDX_W+1)'(PORTS);
      end
      for (int i = 0; i < PORTS; i++) begin
        if ((cand == (IDX_W+1)'(i)) && up_xfcp_in_tvalid[i]) begin
          pick     = IDX_W'(i);
          pick_vld = 1'b1;
        end
      end
    end
  end

  logic [IDX_W-1:0] grant_nxt;
  assign grant_nxt = (grant_q == IDX_W'(PORTS - 1)) ? '0 : grant_q + 1'b1;

  logic req_last_hs, resp_hs;
  assign req_last_hs = (state_q == ST_REQ) && sel_tvalid && down_xfcp_out_tready && sel_tlast;
  assign resp_hs     = (state_q == ST_RESP) && down_xfcp_in_tvalid && sel_out_tready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    mid_resp_d    = mid_resp_q;
    timeout_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stray response data must be cleared out before a new request goes down
        if (down_xfcp_in_tvalid) begin
          state_d = ST_DROP;
        end else if (pick_vld) begin
          grant_d = pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_last_hs) begin
          rr_ptr_d   = grant_nxt;
          timer_d    = '0;
          mid_resp_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        // A beat in the expiry cycle wins over the timeout
        if (resp_hs) begin
          timer_d = '0;
          if (down_xfcp_in_tlast) begin
            state_d = ST_IDLE;
          end else begin
            mid_resp_d = 1'b1;
          end
        end else if (TMO_EN && (timer_q == TMO_LAST)) begin
          timeout_pulse = 1'b1;
          mid_resp_d    = 1'b0;
          state_d       = mid_resp_q ? ST_DROP : ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DROP: begin
        if (down_xfcp_in_tvalid && down_xfcp_in_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      mid_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      mid_resp_q <= mid_resp_d;
    end
  end

  // Datapath muxing; everything is zero outside the state that owns the path
  always_comb begin
    up_xfcp_in_tready    = '0;
    up_xfcp_out_tdata    = '0;
    up_xfcp_out_tvalid   = '0;
    up_xfcp_out_tlast    = '0;
    up_xfcp_out_tuser    = '0;
    down_xfcp_out_tdata  = '0;
    down_xfcp_out_tvalid = 1'b0;
    down_xfcp_out_tlast  = 1'b0;
    down_xfcp_out_tuser  = 1'b0;
    down_xfcp_in_tready  = 1'b0;
    case (state_q)
      ST_REQ: begin
        down_xfcp_out_tdata  = sel_tdata;
        down_xfcp_out_tvalid = sel_tvalid;
        down_xfcp_out_tlast  = sel_tlast;
        down_xfcp_out_tuser  = sel_tuser;
        up_xfcp_in_tready    = gnt_oh & {PORTS{down_xfcp_out_tready}};
      end
      ST_RESP: begin
        up_xfcp_out_tdata   = {PORTS{down_xfcp_in_tdata}};
        up_xfcp_out_tvalid  = gnt_oh & {PORTS{down_xfcp_in_tvalid}};
        up_xfcp_out_tlast   = gnt_oh & {PORTS{down_xfcp_in_tlast}};
        up_xfcp_out_tuser   = gnt_oh & {PORTS{down_xfcp_in_tuser}};
        down_xfcp_in_tready = sel_out_tready;
      end
      ST_DROP: begin
        down_xfcp_in_tready = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule
